// File: rtl/pipe_adder_nbit.sv
// Pipelined N-bit adder: each stage adds one SEG-bit slice, with carry and valid
// travelling alongside the operands. Supports stall, synchronous flush and a sticky overflow flag.

module pipe_adder_nbit_chk #(
  parameter int NUM_BITS = 16
) (
  input logic                clk,
  input logic                rst,
  input logic                in_valid,
  input logic                stall,
  input logic                clear,
  input logic [NUM_BITS-1:0] a,
  input logic [NUM_BITS-1:0] b
);

  // operands must be fully known whenever a transaction is taken
  operands_known_a: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !stall && !clear) |-> !$isunknown({a, b}))
    else $error("pipe_adder_nbit: X/Z on a or b at an accepting edge");

endmodule

module pipe_adder_nbit #(
  parameter int NUM_BITS   = 16,
  parameter int NUM_STAGES = 4,
  parameter bit SIGNED     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  input  logic                in_valid,
  input  logic                stall,
  input  logic                clear,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow,
  output logic                out_valid,
  output logic                sticky_overflow
);

  localparam int SEG  = NUM_BITS / NUM_STAGES;
  localparam int LAST = NUM_STAGES - 1;
  localparam int PD   = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  // combinational view of what each stage sees and produces
  logic [NUM_BITS-1:0] st_a_s   [NUM_STAGES];
  logic [NUM_BITS-1:0] st_b_s   [NUM_STAGES];
  logic [NUM_BITS-1:0] st_p_s   [NUM_STAGES];
  logic [NUM_BITS-1:0] st_nxt_s [NUM_STAGES];
  logic                st_c_s   [NUM_STAGES];
  logic                st_v_s   [NUM_STAGES];
  logic                st_co_s  [NUM_STAGES];

  // inter-stage registers (stage k output feeds stage k+1)
  logic [NUM_BITS-1:0] a_r [PD];
  logic [NUM_BITS-1:0] b_r [PD];
  logic [NUM_BITS-1:0] p_r [PD];
  logic                c_r [PD];
  logic                v_r [PD];

  logic ov_s;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [SEG:0]          seg_s;
    logic [NUM_BITS-1:0]   nxt_s;

    if (k == 0) begin : g_first
      assign st_a_s[k] = a;
      assign st_b_s[k] = b;
      assign st_p_s[k] = {NUM_BITS{1'b0}};
      assign st_c_s[k] = carry_in;
      assign st_v_s[k] = in_valid;
    end else begin : g_later
      assign st_a_s[k] = a_r[k-1];
      assign st_b_s[k] = b_r[k-1];
      assign st_p_s[k] = p_r[k-1];
      assign st_c_s[k] = c_r[k-1];
      assign st_v_s[k] = v_r[k-1];
    end

    assign seg_s = {1'b0, st_a_s[k][k*SEG +: SEG]}
                 + {1'b0, st_b_s[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, st_c_s[k]};
    assign st_co_s[k] = seg_s[SEG];

    // merge this stage's slice into the partial sum carried from lower stages
    always_comb begin
      nxt_s = st_p_s[k];
      nxt_s[k*SEG +: SEG] = seg_s[SEG-1:0];
    end

    assign st_nxt_s[k] = nxt_s;
  end

  if (SIGNED) begin : g_ov_signed
    assign ov_s = (st_a_s[LAST][NUM_BITS-1] == st_b_s[LAST][NUM_BITS-1]) &&
                  (st_nxt_s[LAST][NUM_BITS-1] != st_a_s[LAST][NUM_BITS-1]);
  end else begin : g_ov_unsigned
    assign ov_s = st_co_s[LAST];
  end

  // inter-stage pipeline registers; flush kills valids only, stall freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PD; k++) begin
        v_r[k] <= 1'b0;
        c_r[k] <= 1'b0;
        a_r[k] <= {NUM_BITS{1'b0}};
        b_r[k] <= {NUM_BITS{1'b0}};
        p_r[k] <= {NUM_BITS{1'b0}};
      end
    end else if (clear) begin
      for (int k = 0; k < NUM_STAGES - 1; k++) begin
        v_r[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < NUM_STAGES - 1; k++) begin
        v_r[k] <= st_v_s[k];
        c_r[k] <= st_co_s[k];
        a_r[k] <= st_a_s[k];
        b_r[k] <= st_b_s[k];
        p_r[k] <= st_nxt_s[k];
      end
    end else begin
      for (int k = 0; k < NUM_STAGES - 1; k++) begin
        v_r[k] <= v_r[k];
      end
    end
  end

  // output stage: sum/overflow only load on a completed transaction, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum             <= {NUM_BITS{1'b0}};
      overflow        <= 1'b0;
      out_valid       <= 1'b0;
      sticky_overflow <= 1'b0;
    end else if (clear) begin
      out_valid       <= 1'b0;
      sticky_overflow <= 1'b0;
    end else if (!stall) begin
      out_valid <= st_v_s[LAST];
      if (st_v_s[LAST]) begin
        sum             <= st_nxt_s[LAST];
        overflow        <= ov_s;
        sticky_overflow <= sticky_overflow | ov_s;
      end else begin
        sticky_overflow <= sticky_overflow;
      end
    end else begin
      out_valid <= out_valid;
    end
  end

  pipe_adder_nbit_chk #(
    .NUM_BITS (NUM_BITS)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .stall    (stall),
    .clear    (clear),
    .a        (a),
    .b        (b)
  );

endmodule

// File: tb/tb_pipe_adder_nbit.sv
// Directed and model-compared bench for pipe_adder_nbit: 4-stage unsigned/signed
// builds get hand-computed vectors; 1-, 4- and 16-stage builds run random traffic.

module tb_pipe_adder_nbit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        carry_in, in_valid, stall, clear;

  logic [15:0] sum_u, sum_s, sum_1, sum_16;
  logic        ov_u, ov_s, ov_1, ov_16;
  logic        vld_u, vld_s, vld_1, vld_16;
  logic        stk_u, stk_s, stk_1, stk_16;

  always #5 clk = ~clk;

  pipe_adder_nbit #(.NUM_BITS(16), .NUM_STAGES(4), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(carry_in), .in_valid(in_valid),
    .stall(stall), .clear(clear), .sum(sum_u), .overflow(ov_u), .out_valid(vld_u),
    .sticky_overflow(stk_u));

  pipe_adder_nbit #(.NUM_BITS(16), .NUM_STAGES(4), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(carry_in), .in_valid(in_valid),
    .stall(stall), .clear(clear), .sum(sum_s), .overflow(ov_s), .out_valid(vld_s),
    .sticky_overflow(stk_s));

  pipe_adder_nbit #(.NUM_BITS(16), .NUM_STAGES(1), .SIGNED(1'b0)) dut_1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(carry_in), .in_valid(in_valid),
    .stall(stall), .clear(clear), .sum(sum_1), .overflow(ov_1), .out_valid(vld_1),
    .sticky_overflow(stk_1));

  pipe_adder_nbit #(.NUM_BITS(16), .NUM_STAGES(16), .SIGNED(1'b0)) dut_16 (
    .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(carry_in), .in_valid(in_valid),
    .stall(stall), .clear(clear), .sum(sum_16), .overflow(ov_16), .out_valid(vld_16),
    .sticky_overflow(stk_16));

  // instance views for the random phase: 0 = 1 stage, 1 = 4 stages, 2 = 16 stages
  logic [15:0] r_sum [3];
  logic        r_ov  [3];
  logic        r_vld [3];
  logic        r_stk [3];
  assign r_sum[0] = sum_1;  assign r_sum[1] = sum_u;  assign r_sum[2] = sum_16;
  assign r_ov[0]  = ov_1;   assign r_ov[1]  = ov_u;   assign r_ov[2]  = ov_16;
  assign r_vld[0] = vld_1;  assign r_vld[1] = vld_u;  assign r_vld[2] = vld_16;
  assign r_stk[0] = stk_1;  assign r_stk[1] = stk_u;  assign r_stk[2] = stk_16;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // reference model: whole-word result shifted through a depth-D delay line
  int          dep [3] = '{1, 4, 16};
  logic        mv  [3][16];
  logic [16:0] mr  [3][16];
  logic        ev  [3];
  logic [15:0] es  [3];
  logic        eov [3];
  logic        est [3];
  bit          model_on = 1'b0;

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        for (int j = 0; j < 16; j++) mv[i][j] = 1'b0;
        ev[i]  = 1'b0;
        est[i] = 1'b0;
      end else if (!stall) begin
        for (int j = dep[i] - 1; j > 0; j--) begin
          mv[i][j] = mv[i][j-1];
          mr[i][j] = mr[i][j-1];
        end
        mv[i][0] = in_valid;
        mr[i][0] = {1'b0, a} + {1'b0, b} + {16'd0, carry_in};
        ev[i] = mv[i][dep[i]-1];
        if (ev[i]) begin
          es[i]  = mr[i][dep[i]-1][15:0];
          eov[i] = mr[i][dep[i]-1][16];
          est[i] = est[i] | eov[i];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on) model_step();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; stall = 1'b0; clear = 1'b0; carry_in = 1'b0;
    a = 16'h0000; b = 16'h0000;
  endtask

  task automatic drive_txn(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
    in_valid = 1'b1; stall = 1'b0; clear = 1'b0;
    a = ta; b = tb_; carry_in = tc;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        ovu;
    logic        ovs;
  } vec_t;

  vec_t vecs [10];

  typedef struct {
    logic        v;
    logic [15:0] s;
    logic        ov;
  } exp_t;

  exp_t seq_exp [10];

  initial begin
    int accepted;
    int cyc;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[4] = '{16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[8] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[9] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};

    // back-to-back with a two-cycle stall once the first result is out
    seq_exp[0] = '{1'b0, 16'h0000, 1'b0};
    seq_exp[1] = '{1'b0, 16'h0000, 1'b0};
    seq_exp[2] = '{1'b0, 16'h0000, 1'b0};
    seq_exp[3] = '{1'b1, 16'h0003, 1'b0};
    seq_exp[4] = '{1'b1, 16'h0003, 1'b0};
    seq_exp[5] = '{1'b1, 16'h0003, 1'b0};
    seq_exp[6] = '{1'b1, 16'h5555, 1'b0};
    seq_exp[7] = '{1'b1, 16'h0101, 1'b0};
    seq_exp[8] = '{1'b1, 16'h0000, 1'b1};
    seq_exp[9] = '{1'b0, 16'h0000, 1'b0};

    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    chk("reset_sum", sum_u, 16'h0000);
    chk("reset_vld", vld_u, 1'b0);
    chk("reset_stk", stk_u, 1'b0);
    rst = 1'b0;

    // single transactions: latency, result, overflow flavours, sticky
    for (int i = 0; i < 10; i++) begin
      clear = 1'b1;
      tick();
      chk($sformatf("v%0d_clr_stk", i), stk_u, 1'b0);
      drive_txn(vecs[i].a, vecs[i].b, vecs[i].cin);
      tick();
      drive_idle();
      tick();
      tick();
      chk($sformatf("v%0d_early_vld", i), vld_u, 1'b0);
      tick();
      chk($sformatf("v%0d_vld", i), vld_u, 1'b1);
      chk($sformatf("v%0d_sum", i), sum_u, vecs[i].s);
      chk($sformatf("v%0d_ovu", i), ov_u, vecs[i].ovu);
      chk($sformatf("v%0d_stku", i), stk_u, vecs[i].ovu);
      chk($sformatf("v%0d_sum_s", i), sum_s, vecs[i].s);
      chk($sformatf("v%0d_ovs", i), ov_s, vecs[i].ovs);
      tick();
      chk($sformatf("v%0d_vld_drop", i), vld_u, 1'b0);
      chk($sformatf("v%0d_stku_hold", i), stk_u, vecs[i].ovu);
      chk($sformatf("v%0d_stks_hold", i), stk_s, vecs[i].ovs);
    end

    // asynchronous reset while a result is on the outputs
    clear = 1'b1;
    tick();
    drive_txn(16'h7FFF, 16'h7FFF, 1'b1);
    tick();
    drive_idle();
    tick(); tick(); tick();
    chk("pre_rst_vld", vld_s, 1'b1);
    chk("pre_rst_stk", stk_s, 1'b1);
    drive_txn(16'h1111, 16'h1111, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_sum_u", sum_u, 16'h0000);
    chk("arst_ov_u", ov_u, 1'b0);
    chk("arst_vld_u", vld_u, 1'b0);
    chk("arst_sum_s", sum_s, 16'h0000);
    chk("arst_ov_s", ov_s, 1'b0);
    chk("arst_vld_s", vld_s, 1'b0);
    chk("arst_stk_s", stk_s, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive_txn(16'h0001, 16'h0002, 1'b0);
    tick();
    drive_idle();
    tick(); tick();
    chk("post_rst_early", vld_u, 1'b0);
    tick();
    chk("post_rst_vld", vld_u, 1'b1);
    chk("post_rst_sum", sum_u, 16'h0003);
    tick();
    chk("post_rst_flush", vld_u, 1'b0);

    // back-to-back stream with stall holding the first result
    clear = 1'b1;
    tick();
    for (int e = 0; e < 10; e++) begin
      case (e)
        0: drive_txn(16'h0001, 16'h0002, 1'b0);
        1: drive_txn(16'h1234, 16'h4321, 1'b0);
        2: drive_txn(16'h00FF, 16'h0001, 1'b1);
        3: drive_txn(16'h8000, 16'h8000, 1'b0);
        4, 5: begin drive_txn(16'h1111, 16'h2222, 1'b0); stall = 1'b1; end
        default: drive_idle();
      endcase
      tick();
      chk($sformatf("b2b_e%0d_vld", e), vld_u, seq_exp[e].v);
      if (seq_exp[e].v) begin
        chk($sformatf("b2b_e%0d_sum", e), sum_u, seq_exp[e].s);
        chk($sformatf("b2b_e%0d_ov", e), ov_u, seq_exp[e].ov);
      end
      chk($sformatf("b2b_e%0d_stk", e), stk_u, (e >= 8) ? 1'b1 : 1'b0);
    end

    // clear with three transactions in flight, asserted together with stall
    drive_txn(16'hFFFF, 16'h0001, 1'b0);
    tick();
    drive_txn(16'h8000, 16'h8000, 1'b0);
    tick();
    drive_txn(16'h0001, 16'h0002, 1'b0);
    tick();
    chk("clr_pre_stk", stk_u, 1'b1);
    drive_txn(16'hFFFF, 16'hFFFF, 1'b1);
    stall = 1'b1;
    clear = 1'b1;
    tick();
    chk("clr_vld", vld_u, 1'b0);
    chk("clr_stk", stk_u, 1'b0);
    drive_idle();
    for (int e = 0; e < 6; e++) begin
      tick();
      chk($sformatf("clr_drain%0d_vld", e), vld_u, 1'b0);
      chk($sformatf("clr_drain%0d_stk", e), stk_u, 1'b0);
    end

    // random traffic against the delay-line model for 1, 4 and 16 stages
    model_on = 1'b1;
    clear = 1'b1;
    tick();
    accepted = 0;
    cyc = 0;
    while (accepted < 500 && cyc < 5000) begin
      a        = 16'($urandom);
      b        = 16'($urandom);
      carry_in = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 7) == 0);
      clear    = ($urandom_range(0, 149) == 0);
      if (in_valid && !stall && !clear) accepted++;
      tick();
      cyc++;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rnd_d%0d_vld", dep[i]), r_vld[i], ev[i]);
        chk($sformatf("rnd_d%0d_stk", dep[i]), r_stk[i], est[i]);
        if (ev[i]) begin
          chk($sformatf("rnd_d%0d_sum", dep[i]), r_sum[i], es[i]);
          chk($sformatf("rnd_d%0d_ov", dep[i]), r_ov[i], eov[i]);
        end
      end
    end
    chk("rnd_accepted", (accepted >= 500) ? 1'b1 : 1'b0, 1'b1);
    drive_idle();
    for (int e = 0; e < 20; e++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("drain_d%0d_vld", dep[i]), r_vld[i], ev[i]);
        if (ev[i]) chk($sformatf("drain_d%0d_sum", dep[i]), r_sum[i], es[i]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_adder_nbit.md
PIPE_ADDER_NBIT -- requirements
Module: pipe_adder_nbit

Interface
REQ-001 SHALL have parameter NUM_BITS, default 16: operand and sum width; legal range 2 to 64.
REQ-002 SHALL have parameter NUM_STAGES, default 4: pipeline depth; NUM_BITS mod NUM_STAGES SHALL be 0; SEG = NUM_BITS/NUM_STAGES.
REQ-003 SHALL have parameter SIGNED, default 0: 0 = unsigned overflow (carry-out), 1 = two's-complement overflow.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port a, input, NUM_BITS: operand A.
REQ-007 SHALL have port b, input, NUM_BITS: operand B.
REQ-008 SHALL have port carry_in, input, 1 bit: carry into bit 0.
REQ-009 SHALL have port in_valid, input, 1 bit: a/b/carry_in valid this cycle.
REQ-010 SHALL have port stall, input, 1 bit: freeze the pipeline.
REQ-011 SHALL have port clear, input, 1 bit: synchronous flush.
REQ-012 SHALL have port sum, output, NUM_BITS: result.
REQ-013 SHALL have port overflow, output, 1 bit: overflow of the result on sum.
REQ-014 SHALL have port out_valid, output, 1 bit: sum/overflow hold a completed transaction.
REQ-015 SHALL have port sticky_overflow, output, 1 bit: set by any completed transaction with overflow.

Function
REQ-016 Stage k (0..NUM_STAGES-1) SHALL add bits [k*SEG +: SEG] of A and B plus the carry registered from stage k-1 (carry_in for k=0), registering the SEG-bit partial sum and carry-out.
REQ-017 Operand slices for later stages SHALL be delayed by k registers; completed low slices SHALL be delayed so all slices of one transaction reach the output together.
REQ-018 A transaction SHALL be accepted at rising edge t iff in_valid=1, stall=0, clear=0, rst=0.
REQ-019 An accepted transaction SHALL appear on sum/overflow with out_valid=1 immediately after edge t+NUM_STAGES-1: latency NUM_STAGES edges; NUM_STAGES=1 gives a single registered adder.
REQ-020 sum SHALL equal (A + B + carry_in) mod 2^NUM_BITS.
REQ-021 SIGNED=0: overflow SHALL be carry-out of bit NUM_BITS-1; SIGNED=1: overflow SHALL be 1 iff A and B have equal MSBs and sum MSB differs.
REQ-022 A per-stage valid bit SHALL travel with each transaction; bubbles (in_valid=0) SHALL yield out_valid=0 in the corresponding output cycle.
REQ-023 Back-to-back transactions SHALL be accepted every cycle; order SHALL be preserved; throughput one per cycle.
REQ-024 stall=1 SHALL hold every pipeline and output register, including out_valid and sticky_overflow; in_valid SHALL be ignored.
REQ-025 clear=1 SHALL zero all valid bits, out_valid and sticky_overflow at the next edge; clear SHALL take priority over stall and in_valid; in-flight transactions SHALL be discarded.
REQ-026 sticky_overflow SHALL set at the edge an overflowing transaction reaches the output and hold until clear or rst.
REQ-027 When out_valid=0, sum and overflow SHALL hold their last values and SHALL NOT be checked by the bench.
REQ-028 A simulation-only assertion SHALL issue $error when in_valid=1 at an accepting edge and a or b contains X or Z.

Reset
REQ-029 rst=1 SHALL immediately, without a clock, force sum=0, overflow=0, out_valid=0, sticky_overflow=0 and all stage valid bits to 0.
REQ-030 Reset mid-operation SHALL discard all in-flight transactions; the first edge after rst falls SHALL be able to accept a new one.

Verification (NUM_BITS=16, NUM_STAGES=4 unless stated)
REQ-031 Assert rst asynchronously between edges -> all outputs 0 before the next edge.
REQ-032 a=0xFFFF, b=0x0001, carry_in=0, one valid cycle at edge t -> out_valid=1 for one cycle after edge t+3, sum=0x0000, overflow=1, sticky_overflow=1 thereafter.
REQ-033 Four back-to-back transactions (0x0001+0x0002, 0x1234+0x4321, 0x00FF+0x0001 with carry_in=1, 0x8000+0x8000); stall=1 for 2 cycles mid-stream -> outputs 0x0003, 0x5555, 0x0101, 0x0000/ov=1, in order, each result held during stall.
REQ-034 clear=1 with 3 transactions in flight and stall=1 -> out_valid=0 and sticky_overflow=0 after that edge; no results emerge later.
REQ-035 SIGNED=1: 0x7FFF+0x0001 -> sum=0x8000, overflow=1; 0xFFFF+0x0001 -> sum=0x0000, overflow=0.
REQ-036 NUM_STAGES=1 and NUM_STAGES=16 builds: 500 random transactions with random bubbles and stalls, compared against a reference model -> zero mismatches.
